sort_engine: RTL and testbench
==============================

# sort_engine

Self-contained, parametrised in-place exchange sorter: a host loads K words of N bits through a RAM port, pulses `start`, and the engine sorts the buffer ascending or descending, then raises `done`. It merges the sorting datapath with its control FSM, adds a run-time sort direction and busy/done status, and sits between the host load/unload interface and downstream readers of the sorted buffer.

## Interface
Parameters:
- N, 8: data word width (bits).
- L, 4: address width.
- K, 8: element count; legal range 2 ≤ K ≤ 2^L.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin sort; sampled only in IDLE.
- Desc  in  1  0 = ascending, 1 = descending; sampled with `start`.
- WrInit  in  1  host write of `DataIn` to M[RAddr].
- Rd  in  1  host read enable.
- RAddr  in  L  host address.
- DataIn  in  N  host write data.
- DataOut  out  N  M[RAddr] when `Rd`=1 and not busy, else 0.
- busy  out  1  high from start-accept until the sort completes.
- done  out  1  sticky; set at completion, cleared on next start-accept.
- SwapCnt  out  SW  swap count; present only with SORT_SWAP_COUNT_EN. SW = $clog2(K*(K-1)/2+1).

## Operation
- Algorithm: for i = 0..K-2, for j = i+1..K-1: A=M[i], B=M[j]. If swap condition holds, M[i]←B, M[j]←A, A←B. Swap condition is A>B (ascending) or A<B (descending). The comparison is strict, so equal keys never swap.
- RAM: K words, synchronous write, combinational read, not reset.
- Host access only when busy=0. While busy, `WrInit` and `Rd` are ignored and DataOut=0.
- Host accesses with RAddr ≥ K: writes are dropped; reads return 0.
- `start` while busy is ignored.
- FSM states and transitions:
  - IDLE: on start=1, i←0, latch Desc, clear done, busy←1, → LDA.
  - LDA: A←M[i], j←i+1 → LDB.
  - LDB: B←M[j] → CMP.
  - CMP: swap ? → WRI : → NXJ.
  - WRI: M[i]←B → WRJ.
  - WRJ: M[j]←A, A←B → NXJ.
  - NXJ: j==K-1 ? → NXI : j←j+1, → LDB.
  - NXI: i==K-2 ? busy←0, done←1, → IDLE : i←i+1, → LDA.
- Reset (any time): FSM→IDLE; i, j, A, B, busy, done, SwapCnt←0; DataOut=0.
- RAM contents after a reset taken mid-sort are unspecified. The host must reload.
- Simultaneous `start` and `WrInit` in IDLE: the write lands in the same edge, before the sort reads begin.

## Timing
- Sort latency, from the start-accepting edge to the edge where done rises: 2(K-1) + 3·P + 2·S cycles.
  - P = K(K-1)/2 is the number of compare pairs.
  - S is the number of swaps.
  - Defaults: 98 + 2S cycles.
- `busy` falls and `done` rises on the same edge.
- Host read: DataOut is valid combinationally in the same cycle as `Rd` and RAddr.
- Host write: visible to reads on the following cycle.

## Configuration
- SORT_SWAP_COUNT_EN defined:
  - `SwapCnt` port exists.
  - Cleared on start-accept; increments by 1 on each CMP cycle whose swap condition holds.
  - Holds its value after done; cannot overflow, given the SW width.
- Not defined: port, counter and associated logic are absent. All other behaviour is identical.

## Structure
- Package sort_pkg holds:
  - the FSM state enum typedef (IDLE, LDA, LDB, CMP, WRI, WRJ, NXJ, NXI);
  - a constant function computing SW from K.
- Sub-module sort_ram: K×N storage, one synchronous write port and one combinational read port. It is shared between the host path and the FSM path via an address/data mux keyed on busy.
- The FSM, counters i and j, registers A and B, and the comparator live in sort_engine.

## Test plan
- Reset: assert rst=0 mid-sort (state WRJ) → busy=0, done=0, DataOut=0, FSM idle; next start runs a full sort after reload.
- Ascending pre-sorted {0..7}, Desc=0 → done rises exactly 98 cycles after the start edge; readback {0..7}; SwapCnt=0.
- Single inversion {1,0,2,3,4,5,6,7}, Desc=0 → done at 100 cycles; readback {0..7}; SwapCnt=1.
- Reverse {7..0}, Desc=0 → readback {0..7}. Same buffer re-sorted with Desc=1 → readback {7..0}. For each run, the count of WRI cycles equals the final SwapCnt.
- All-equal {5×8} with duplicates mixed {3,1,3,0,1,3,0,2}, Desc=0 → {0,0,1,1,2,3,3,3}. The all-equal run yields SwapCnt=0 and a 98-cycle latency.
- Host accesses during busy:
  - `WrInit` to address 2 mid-sort → write is ignored and the final buffer is unaffected.
  - `Rd` mid-sort → DataOut=0.
  - `start` pulse mid-sort → no restart.
  - RAddr=9 write/read with L=4, K=8 → dropped, and the read returns 0.

Source files
------------

// File: rtl/sort_pkg.sv
// Shared types for the in-place exchange sorter: FSM state encoding and
// the swap-counter width helper.
package sort_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LDA,
    LDB,
    CMP,
    WRI,
    WRJ,
    NXJ,
    NXI
  } state_t;

  // Enough bits to hold the worst case of one swap per compare pair.
  function automatic int sw_width(input int k);
    return $clog2(k * (k - 1) / 2 + 1);
  endfunction

endpackage

// File: rtl/sort_ram.sv
// K x N buffer: one synchronous write port, one combinational read port.
// Addresses at or beyond K drop writes and read back as zero.
module sort_ram #(
  parameter int N = 8,
  parameter int L = 4,
  parameter int K = 8
) (
  input  logic         clk,
  input  logic         we_i,
  input  logic [L-1:0] waddr_i,
  input  logic [N-1:0] wdata_i,
  input  logic [L-1:0] raddr_i,
  output logic [N-1:0] rdata_o
);

  localparam int AW = (K > 1) ? $clog2(K) : 1;
  localparam logic [L:0] K_LIM = (L + 1)'(K);

  logic [N-1:0] mem [K];
  logic         w_in_range;
  logic         r_in_range;

  assign w_in_range = {1'b0, waddr_i} < K_LIM;
  assign r_in_range = {1'b0, raddr_i} < K_LIM;

  always_ff @(posedge clk) begin
    if (we_i && w_in_range) begin
      mem[waddr_i[AW-1:0]] <= wdata_i;
    end
  end

  assign rdata_o = r_in_range ? mem[raddr_i[AW-1:0]] : '0;

endmodule

// File: rtl/sort_engine.sv
// In-place exchange sorter with run-time direction and busy/done status.
// Optional swap counter port is enabled by defining SORT_SWAP_COUNT_EN.
module sort_engine
  import sort_pkg::*;
#(
  parameter  int N  = 8,
  parameter  int L  = 4,
  parameter  int K  = 8,
  localparam int SW = sw_width(K)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          Desc,
  input  logic          WrInit,
  input  logic          Rd,
  input  logic [L-1:0]  RAddr,
  input  logic [N-1:0]  DataIn,
  output logic [N-1:0]  DataOut,
  output logic          busy,
  output logic          done,
`ifdef SORT_SWAP_COUNT_EN
  output logic [SW-1:0] SwapCnt,
`endif
  output state_t        state_o
);

  localparam logic [L:0]   K_LIM  = (L + 1)'(K);
  localparam logic [L-1:0] J_LAST = L'(K - 1);
  localparam logic [L-1:0] I_LAST = L'(K - 2);

  state_t       state_q, state_d;
  logic [L-1:0] i_q, i_d, j_q, j_d;
  logic [N-1:0] a_q, a_d, b_q, b_d;
  logic         desc_q, desc_d;
  logic         done_q, done_d;

  logic         swap;
  logic         host_ok;
  logic         ram_we;
  logic [L-1:0] ram_waddr, ram_raddr;
  logic [N-1:0] ram_wdata, ram_rdata;

  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign state_o = state_q;
  assign swap    = desc_q ? (a_q < b_q) : (a_q > b_q);
  assign host_ok = {1'b0, RAddr} < K_LIM;
  assign DataOut = (rst && Rd && !busy && host_ok) ? ram_rdata : '0;

  // The host owns the RAM port while idle; the FSM owns it while busy.
  always_comb begin
    ram_raddr = RAddr;
    ram_we    = WrInit;
    ram_waddr = RAddr;
    ram_wdata = DataIn;
    if (busy) begin
      ram_raddr = (state_q == LDA) ? i_q : j_q;
      ram_we    = (state_q == WRI) || (state_q == WRJ);
      ram_waddr = (state_q == WRI) ? i_q : j_q;
      ram_wdata = (state_q == WRI) ? b_q : a_q;
    end
  end

  sort_ram #(.N(N), .L(L), .K(K)) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    a_d     = a_q;
    b_d     = b_q;
    desc_d  = desc_q;
    done_d  = done_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          i_d     = '0;
          desc_d  = Desc;
          done_d  = 1'b0;
          state_d = LDA;
        end
      end
      LDA: begin
        a_d     = ram_rdata;
        j_d     = i_q + 1'b1;
        state_d = LDB;
      end
      LDB: begin
        b_d     = ram_rdata;
        state_d = CMP;
      end
      CMP: state_d = swap ? WRI : NXJ;
      WRI: state_d = WRJ;
      WRJ: begin
        // A follows the element now sitting at M[i].
        a_d     = b_q;
        state_d = NXJ;
      end
      NXJ: begin
        if (j_q == J_LAST) begin
          state_d = NXI;
        end else begin
          j_d     = j_q + 1'b1;
          state_d = LDB;
        end
      end
      NXI: begin
        if (i_q == I_LAST) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          i_d     = i_q + 1'b1;
          state_d = LDA;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      desc_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      a_q     <= a_d;
      b_q     <= b_d;
      desc_q  <= desc_d;
      done_q  <= done_d;
    end
  end

`ifdef SORT_SWAP_COUNT_EN
  logic [SW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE && start) begin
      cnt_d = '0;
    end else if (state_q == CMP && swap) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign SwapCnt = cnt_q;
`endif

endmodule

// File: tb/tb_sort_engine.sv
// Directed bench for sort_engine: latency, readback, host gating and reset.
// Swap-counter checks are compiled in when SORT_SWAP_COUNT_EN is defined.
module tb_sort_engine;
  import sort_pkg::*;

  localparam int N = 8;
  localparam int L = 4;
  localparam int K = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         Desc = 1'b0;
  logic         WrInit = 1'b0;
  logic         Rd = 1'b0;
  logic [L-1:0] RAddr = '0;
  logic [N-1:0] DataIn = '0;
  logic [N-1:0] DataOut;
  logic         busy;
  logic         done;
  state_t       state_o;
`ifdef SORT_SWAP_COUNT_EN
  logic [sw_width(K)-1:0] SwapCnt;
`endif

  sort_engine #(.N(N), .L(L), .K(K)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .Desc    (Desc),
    .WrInit  (WrInit),
    .Rd      (Rd),
    .RAddr   (RAddr),
    .DataIn  (DataIn),
    .DataOut (DataOut),
    .busy    (busy),
    .done    (done),
`ifdef SORT_SWAP_COUNT_EN
    .SwapCnt (SwapCnt),
`endif
    .state_o (state_o)
  );

  always #5 clk = ~clk;

  int           n_vec = 0;
  int           n_err = 0;
  logic [N-1:0] exp_q[$];
  logic [N-1:0] load_v [K];
  logic [N-1:0] exp_v  [K];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic host_write(input logic [L-1:0] a, input logic [N-1:0] d);
    WrInit = 1'b1;
    RAddr  = a;
    DataIn = d;
    @(posedge clk);
    #1;
    WrInit = 1'b0;
  endtask

  task automatic host_read(input logic [L-1:0] a, input logic [N-1:0] exp, input string tag);
    Rd    = 1'b1;
    RAddr = a;
    @(negedge clk);
    chk(tag, DataOut, exp);
    Rd = 1'b0;
  endtask

  task automatic load_buf();
    for (int i = 0; i < K; i++) host_write(L'(i), load_v[i]);
  endtask

  task automatic readback(input string tag);
    for (int i = 0; i < K; i++) exp_q.push_back(exp_v[i]);
    for (int i = 0; i < K; i++) host_read(L'(i), exp_q.pop_front(), $sformatf("%s[%0d]", tag, i));
  endtask

  task automatic run_sort(input logic d, input int exp_lat, input int exp_sw,
                          input bit inject, input string tag);
    int lat;
    int wri;
    bit fin;
    @(negedge clk);
    Desc  = d;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 0;
    wri = 0;
    fin = 0;
    while (!fin && lat < 1000) begin
      @(posedge clk);
      lat++;
      #1;
      if (state_o == WRI) wri++;
      if (lat == 1) begin
        chk({tag, "_busy_on"}, busy, 1);
        chk({tag, "_done_clr"}, done, 0);
      end
      if (inject && lat == 20) begin
        WrInit = 1'b1;
        RAddr  = 4'd2;
        DataIn = 8'hAA;
        Rd     = 1'b1;
        #1;
        chk({tag, "_rd_busy"}, DataOut, 0);
      end
      if (inject && lat == 21) begin
        WrInit = 1'b0;
        Rd     = 1'b0;
        start  = 1'b1;
      end
      if (inject && lat == 22) begin
        start = 1'b0;
        chk({tag, "_no_restart"}, busy, 1);
      end
      if (done) fin = 1;
    end
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_busy_off"}, busy, 0);
    chk({tag, "_wri_cnt"}, wri, exp_sw);
`ifdef SORT_SWAP_COUNT_EN
    chk({tag, "_swapcnt"}, SwapCnt, exp_sw);
`endif
  endtask

  initial begin
    int guard;
    rst = 1'b0;
    Rd  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_state", state_o, IDLE);
    chk("rst_dout", DataOut, 0);
`ifdef SORT_SWAP_COUNT_EN
    chk("rst_swapcnt", SwapCnt, 0);
`endif
    Rd = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    load_v = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
    exp_v  = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
    load_buf();
    run_sort(1'b0, 98, 0, 1'b0, "sorted");
    readback("sorted_rb");

    host_write(4'd9, 8'h55);
    host_read(4'd9, 8'h00, "oob_read");
    host_read(4'd1, 8'h01, "oob_alias");

    load_v = '{8'd1, 8'd0, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
    load_buf();
    run_sort(1'b0, 100, 1, 1'b0, "one_inv");
    readback("one_inv_rb");

    load_v = '{8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
    load_buf();
    run_sort(1'b0, 154, 28, 1'b1, "rev_asc");
    readback("rev_asc_rb");

    exp_v = '{8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
    run_sort(1'b1, 154, 28, 1'b0, "desc");
    readback("desc_rb");

    load_v = '{8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5};
    exp_v  = '{8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5};
    load_buf();
    run_sort(1'b0, 98, 0, 1'b0, "equal");
    readback("equal_rb");

    load_v = '{8'd3, 8'd1, 8'd3, 8'd0, 8'd1, 8'd3, 8'd0, 8'd2};
    exp_v  = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd3, 8'd3};
    load_buf();
    run_sort(1'b0, 112, 7, 1'b0, "dups");
    readback("dups_rb");

    // Reset taken while the engine is writing M[j].
    load_buf();
    @(negedge clk);
    Desc  = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    guard = 0;
    while (state_o != WRJ && guard < 500) begin
      @(posedge clk);
      #1;
      guard++;
    end
    chk("mid_reach_wrj", state_o, WRJ);
    rst   = 1'b0;
    Rd    = 1'b1;
    RAddr = 4'd0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_state", state_o, IDLE);
    chk("mid_rst_dout", DataOut, 0);
`ifdef SORT_SWAP_COUNT_EN
    chk("mid_rst_swapcnt", SwapCnt, 0);
`endif
    Rd = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    load_buf();
    run_sort(1'b0, 112, 7, 1'b0, "post_rst");
    readback("post_rst_rb");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
